// File: rtl/csa_multiword_seq_if.sv
// Handshake bundle for csa_multiword_seq.
//   master: operand producer / result consumer (drives start, operands, out_ready)
//   slave : the sequencer (drives in_ready, result word, status)
// Signals:
//   start, Cin_init          operation launch and initial carry
//   in_valid/in_ready        operand word handshake (A_word, B_word, LSW first)
//   out_valid/out_ready      result word handshake (Sum_word, out_last, Cout_final)
//   busy, done               status: not idle / last word handed off
interface csa_multiword_seq_if;
  logic        start;
  logic        Cin_init;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A_word;
  logic [15:0] B_word;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Sum_word;
  logic        out_last;
  logic        Cout_final;
  logic        busy;
  logic        done;

  modport master (
    output start, Cin_init, in_valid, A_word, B_word, out_ready,
    input  in_ready, out_valid, Sum_word, out_last, Cout_final, busy, done
  );

  modport slave (
    input  start, Cin_init, in_valid, A_word, B_word, out_ready,
    output in_ready, out_valid, Sum_word, out_last, Cout_final, busy, done
  );
endinterface

// File: rtl/csa_multiword_seq.sv
// Multi-word adder sequencer: one 16-bit carry-select adder reused over WORDS cycles
// to add two (16*WORDS)-bit operands streamed LSW first. The inter-word carry lives
// in carry_q; results leave through a single-stage registered valid/ready output.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  csa_multiword_seq_if.slave (operand input, result output, status)
module csa_multiword_seq #(
  parameter int unsigned WORDS = 4,
  parameter int unsigned CW    = $clog2(WORDS)
) (
  input logic               clk,
  input logic               rst,
  csa_multiword_seq_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  state_e        state_q, state_d;
  logic          carry_q, carry_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_valid_q, out_valid_d;
  logic [15:0]   sum_q, sum_d;
  logic          last_q, last_d;
  logic          cout_q, cout_d;

  logic          in_ready;
  logic          done;
  logic          is_last;
  logic [15:0]   add_sum;
  logic          add_cout;

  // 16-bit carry-select adder: four 4-bit blocks each precompute the sum for carry-in
  // 0 and 1, and the incoming block carry picks one.
  function automatic logic [16:0] csa16(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin);
    logic [15:0] s;
    logic        c;
    logic [4:0]  r0;
    logic [4:0]  r1;
    c = cin;
    s = '0;
    for (int k = 0; k < 4; k++) begin
      r0 = {1'b0, a[4*k +: 4]} + {1'b0, b[4*k +: 4]};
      r1 = r0 + 5'd1;
      s[4*k +: 4] = c ? r1[3:0] : r0[3:0];
      c = c ? r1[4] : r0[4];
    end
    return {c, s};
  endfunction

  assign {add_cout, add_sum} = csa16(bus.A_word, bus.B_word, carry_q);
  assign is_last = (cnt_q == CW'(WORDS - 1));

  always_comb begin
    state_d     = state_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    last_d      = last_q;
    cout_d      = cout_q;
    in_ready    = 1'b0;
    done        = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          carry_d = bus.Cin_init;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        // Single output stage: accept only when it is empty or draining this cycle.
        in_ready = !out_valid_q || bus.out_ready;
        if (bus.in_valid && in_ready) begin
          sum_d       = add_sum;
          out_valid_d = 1'b1;
          last_d      = is_last;
          carry_d     = add_cout;
          cnt_d       = cnt_q + CW'(1);
          if (is_last) begin
            cout_d  = add_cout;
            state_d = StFlush;
          end
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      StFlush: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          done        = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      last_q      <= 1'b0;
      cout_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      last_q      <= last_d;
      cout_q      <= cout_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.Sum_word   = sum_q;
  assign bus.out_last   = last_q;
  assign bus.Cout_final = cout_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.done       = done;

endmodule

// File: tb/tb_csa_multiword_seq.sv
// Self-checking bench for csa_multiword_seq (WORDS=4, 64-bit operations).
// Directed table of operations with constant expected results, randomized operations
// checked against a plain 65-bit arithmetic model, and hand-written reset sequences.
module tb_csa_multiword_seq;

  localparam int W = 4;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  csa_multiword_seq_if bus ();

  csa_multiword_seq #(.WORDS(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [3:0]  rdy_mask;   // out_ready = rdy_mask[cycle % 4]
    int          bubble_at;  // in_valid low once this many words are accepted (-1: none)
    int          bubble_len;
    logic        start_poke; // drive start during RUN and through FLUSH
    logic [63:0] exp_sum;
    logic        exp_cout;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input vec_t v, input logic rand_mode);
    int       acc;
    int       got;
    int       cyc;
    int       gap;
    logic     stalled;
    logic [15:0] held_sum;
    logic     held_last;
    acc = 0; got = 0; cyc = 0; gap = 0; stalled = 1'b0;
    held_sum = '0; held_last = 1'b0;

    chk("idle_before_start", 64'(bus.busy), 64'd0);
    bus.Cin_init = v.cin;
    bus.start    = 1'b1;
    step();
    bus.start    = 1'b0;
    bus.Cin_init = ~v.cin;  // must not be re-sampled mid-operation
    chk("busy_after_start", 64'(bus.busy), 64'd1);

    while (got < W && cyc < 200) begin
      if (rand_mode) begin
        bus.in_valid  = ($urandom_range(0, 3) != 0);
        bus.out_ready = ($urandom_range(0, 2) != 0);
      end else begin
        bus.out_ready = v.rdy_mask[cyc % 4];
        if (acc == v.bubble_at && gap < v.bubble_len) begin
          bus.in_valid = 1'b0;
          gap++;
        end else begin
          bus.in_valid = 1'b1;  // stays high past the last word to probe back-pressure
        end
      end
      bus.A_word = (acc < W) ? v.a[16*acc +: 16] : 16'hDEAD;
      bus.B_word = (acc < W) ? v.b[16*acc +: 16] : 16'hBEEF;
      bus.start  = v.start_poke && (acc == 1 || acc >= W);
      #1;

      if (stalled) begin
        chk("stall_valid", 64'(bus.out_valid), 64'd1);
        chk("stall_sum", 64'(bus.Sum_word), 64'(held_sum));
        chk("stall_last", 64'(bus.out_last), 64'(held_last));
      end
      if (bus.out_valid && !bus.out_ready) chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
      if (acc >= W) chk("extra_word_backpressure", 64'(bus.in_ready), 64'd0);
      chk("busy_in_op", 64'(bus.busy), 64'd1);

      if (bus.out_valid && bus.out_ready) begin
        chk("sum_word", 64'(bus.Sum_word), 64'(v.exp_sum[16*got +: 16]));
        chk("out_last", 64'(bus.out_last), 64'(got == W - 1));
        chk("done_on_handoff", 64'(bus.done), 64'(got == W - 1));
        if (got == W - 1) chk("cout_final", 64'(bus.Cout_final), 64'(v.exp_cout));
        got++;
      end else begin
        chk("done_idle", 64'(bus.done), 64'd0);
      end

      stalled   = bus.out_valid && !bus.out_ready;
      held_sum  = bus.Sum_word;
      held_last = bus.out_last;
      if (bus.in_valid && bus.in_ready) acc++;
      step();
      cyc++;
    end

    if (got < W) begin
      errors++;
      checks++;
      $display("FAIL op_timeout: got %0d words required %0d", got, W);
    end
    if (!rand_mode && v.rdy_mask == 4'hF && v.bubble_at < 0)
      chk("op_cycles", 64'(cyc), 64'(W + 1));

    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("idle_after_op", 64'(bus.busy), 64'd0);
    chk("out_empty_after_op", 64'(bus.out_valid), 64'd0);
    chk("no_second_done", 64'(bus.done), 64'd0);
    chk("cout_holds", 64'(bus.Cout_final), 64'(v.exp_cout));
    step();
  endtask

  vec_t dir [5];
  vec_t rv;
  logic [64:0] model;

  initial begin
    errors = 0;
    checks = 0;
    bus.start = 1'b0; bus.Cin_init = 1'b0; bus.in_valid = 1'b0;
    bus.A_word = '0; bus.B_word = '0; bus.out_ready = 1'b0;

    dir[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 4'hF, -1, 0, 1'b0,
               64'h0, 1'b1};
    dir[1] = '{64'h0, 64'h0, 1'b1, 4'hF, -1, 0, 1'b0,
               64'h1, 1'b0};
    dir[2] = '{64'h0001_8000_7FFF_1234, 64'h0000_8000_0001_EDCC, 1'b0, 4'b1001, -1, 0, 1'b0,
               64'h0002_0000_8001_0000, 1'b0};
    dir[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 4'hF, 2, 3, 1'b0,
               64'h0, 1'b1};
    dir[4] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 4'hF, -1, 0, 1'b1,
               64'h2222_2222_2222_2211, 1'b0};

    // Reset state
    rst = 1'b1;
    repeat (2) step();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_sum", 64'(bus.Sum_word), 64'd0);
    chk("rst_last", 64'(bus.out_last), 64'd0);
    chk("rst_cout", 64'(bus.Cout_final), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    rst = 1'b0;
    step();

    // Operand words without start are not accepted
    bus.in_valid = 1'b1;
    #1;
    chk("idle_in_ready", 64'(bus.in_ready), 64'd0);
    step();
    chk("idle_no_start", 64'(bus.busy), 64'd0);
    bus.in_valid = 1'b0;

    for (int i = 0; i < 5; i++) run_op(dir[i], 1'b0);

    // Reset two words into an operation
    bus.Cin_init = 1'b0;
    bus.start    = 1'b1;
    step();
    bus.start     = 1'b0;
    bus.in_valid  = 1'b1;
    bus.A_word    = 16'hFFFF;
    bus.B_word    = 16'h0001;
    bus.out_ready = 1'b1;
    repeat (2) step();
    chk("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("midop_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("midop_rst_busy", 64'(bus.busy), 64'd0);
    chk("midop_rst_done", 64'(bus.done), 64'd0);
    chk("midop_rst_in_ready", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b0;
    step();
    chk("rst_held_done", 64'(bus.done), 64'd0);
    rst = 1'b0;
    step();
    rv = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 4'hF, -1, 0, 1'b0, 64'h0, 1'b1};
    run_op(rv, 1'b0);

    // Randomized operations against a 65-bit arithmetic model
    for (int n = 0; n < 24; n++) begin
      rv.a          = {$urandom, $urandom};
      rv.b          = {$urandom, $urandom};
      if (n % 4 == 0) rv.b = ~rv.a;  // long carry chains
      rv.cin        = 1'($urandom_range(0, 1));
      rv.rdy_mask   = 4'hF;
      rv.bubble_at  = -1;
      rv.bubble_len = 0;
      rv.start_poke = 1'($urandom_range(0, 1));
      model         = {1'b0, rv.a} + {1'b0, rv.b} + 65'(rv.cin);
      rv.exp_sum    = model[63:0];
      rv.exp_cout   = model[64];
      run_op(rv, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
